pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline; sits beside the forwarding logic and drives

---
 rtl/pipeline_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// It resolves load-use hazards, holds the pipe while a multi-cycle op sits in EX,
// freezes everything while data memory is busy, and flushes IF/ID on taken branches.
// It also keeps a saturating stall-cycle counter and a sticky data-memory watchdog.
//
// Handshake note: there is no valid/ready pair here. The *_Write enables and
// *_Flush bubbles are level signals valid for the current cycle only.
// A stage loads a bubble whenever its Flush is 1, regardless of its Write.
module pipeline_hazard_ctrl #(
    parameter int MUL_LAT     = 4,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_RegRt,
    input  logic [4:0]       IF_ID_RegRs,
    input  logic [4:0]       IF_ID_RegRt,
    input  logic             ID_EX_MultiCycle,
    input  logic             branch_taken,
    input  logic             dmem_busy,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Write,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Write,
    output logic             EX_MEM_Flush,
    output logic             MEM_WB_Flush,
    output logic             ex_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             mem_timeout
);

    typedef enum logic {
        RUN     = 1'b0,
        EX_BUSY = 1'b1
    } state_t;

    localparam int          WD_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [3:0]  MC_INIT = 4'(MUL_LAT - 2);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(MEM_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

    state_t            r_state;
    logic [3:0]        r_mc_cnt;
    logic [CNT_W-1:0]  r_stall_cycles;
    logic [WD_W-1:0]   r_wd_cnt;
    logic              r_mem_timeout;

    state_t            w_state_nxt;
    logic [3:0]        w_mc_nxt;
    logic              w_load_use;
    logic              w_hold;

    // Hazard detection terms from the current inputs and state.
    always_comb begin
        w_load_use = ID_EX_MemRead && (ID_EX_RegRt != 5'd0) &&
                     ((ID_EX_RegRt == IF_ID_RegRs) || (ID_EX_RegRt == IF_ID_RegRt));
        w_hold     = ((r_state == RUN) && ID_EX_MultiCycle) ||
                     ((r_state == EX_BUSY) && (r_mc_cnt != 4'd0));
    end

    // Next-state and control outputs; priority freeze > hold > load-use > branch.
    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Write  = 1'b1;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Write = 1'b1;
        EX_MEM_Flush = 1'b0;
        MEM_WB_Flush = 1'b0;
        ex_busy      = rst_n && (r_state == EX_BUSY);
        w_state_nxt  = r_state;
        w_mc_nxt     = r_mc_cnt;

        if (!rst_n) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
            MEM_WB_Flush = 1'b1;
        end else if (dmem_busy) begin
            // Whole pipe frozen; the op in EX does not consume a cycle.
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            MEM_WB_Flush = 1'b1;
        end else if (w_hold) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Flush = 1'b1;
            if (r_state == RUN) begin
                w_state_nxt = EX_BUSY;
                w_mc_nxt    = MC_INIT;
            end else begin
                w_mc_nxt    = r_mc_cnt - 4'd1;
            end
        end else begin
            // Release cycle (EX_BUSY, mc_cnt==0) advances like a normal cycle.
            if (r_state == EX_BUSY) begin
                w_state_nxt = RUN;
            end
            if (w_load_use) begin
                PC_Write    = 1'b0;
                IF_ID_Write = 1'b0;
                ID_EX_Flush = 1'b1;
            end else if (branch_taken) begin
                IF_ID_Flush = 1'b1;
            end
        end
    end

    // FSM state and multi-cycle countdown register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_mc_cnt <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_mc_cnt <= w_mc_nxt;
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (!PC_Write && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    // Watchdog on consecutive dmem_busy cycles; the flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wd_cnt      <= '0;
            r_mem_timeout <= 1'b0;
        end else if (!dmem_busy) begin
            r_wd_cnt      <= '0;
        end else begin
            if (r_wd_cnt != WD_MAX) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (r_wd_cnt == WD_LAST) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign mem_timeout  = r_mem_timeout;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl with hand-computed control vectors.
module tb_pipeline_hazard_ctrl;

    // Control vector order: PC_W, IFID_W, IFID_F, IDEX_W, IDEX_F, EXMEM_W, EXMEM_F, MEMWB_F
    localparam logic [7:0] C_DEF = 8'b1101_0100;
    localparam logic [7:0] C_RST = 8'b0010_1011;
    localparam logic [7:0] C_FRZ = 8'b0000_0001;
    localparam logic [7:0] C_HLD = 8'b0000_0110;
    localparam logic [7:0] C_LU  = 8'b0001_1100;
    localparam logic [7:0] C_BR  = 8'b1111_0100;

    logic        clk;
    logic        rst_n;
    logic        ID_EX_MemRead;
    logic [4:0]  ID_EX_RegRt;
    logic [4:0]  IF_ID_RegRs;
    logic [4:0]  IF_ID_RegRt;
    logic        ID_EX_MultiCycle;
    logic        branch_taken;
    logic        dmem_busy;
    logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush;
    logic        EX_MEM_Write, EX_MEM_Flush, MEM_WB_Flush;
    logic        ex_busy;
    logic [15:0] stall_cycles;
    logic        mem_timeout;
    logic [7:0]  ctrl;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_stall = 0;

    pipeline_hazard_ctrl #(.MUL_LAT(4), .CNT_W(16), .MEM_TIMEOUT(64)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ID_EX_MemRead    (ID_EX_MemRead),
        .ID_EX_RegRt      (ID_EX_RegRt),
        .IF_ID_RegRs      (IF_ID_RegRs),
        .IF_ID_RegRt      (IF_ID_RegRt),
        .ID_EX_MultiCycle (ID_EX_MultiCycle),
        .branch_taken     (branch_taken),
        .dmem_busy        (dmem_busy),
        .PC_Write         (PC_Write),
        .IF_ID_Write      (IF_ID_Write),
        .IF_ID_Flush      (IF_ID_Flush),
        .ID_EX_Write      (ID_EX_Write),
        .ID_EX_Flush      (ID_EX_Flush),
        .EX_MEM_Write     (EX_MEM_Write),
        .EX_MEM_Flush     (EX_MEM_Flush),
        .MEM_WB_Flush     (MEM_WB_Flush),
        .ex_busy          (ex_busy),
        .stall_cycles     (stall_cycles),
        .mem_timeout      (mem_timeout)
    );

    assign ctrl = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
                   EX_MEM_Write, EX_MEM_Flush, MEM_WB_Flush};

    // Clock and run-time bound.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with inputs already set: check combinational outputs,
    // step the stall model, cross the edge, check the stall counter.
    task automatic cyc(input string tag, input logic [7:0] ec, input logic eb);
        #1;
        check_eq({tag, ".ctrl"}, {24'd0, ctrl}, {24'd0, ec});
        check_eq({tag, ".ex_busy"}, {31'd0, ex_busy}, {31'd0, eb});
        if (!ec[7]) exp_stall++;
        @(negedge clk);
        check_eq({tag, ".stall"}, {16'd0, stall_cycles}, exp_stall);
    endtask

    task automatic clear_inputs();
        ID_EX_MemRead    = 1'b0;
        ID_EX_RegRt      = 5'd0;
        IF_ID_RegRs      = 5'd0;
        IF_ID_RegRt      = 5'd0;
        ID_EX_MultiCycle = 1'b0;
        branch_taken     = 1'b0;
        dmem_busy        = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();

        // Reset: outputs forced while low.
        #1;
        check_eq("rst.ctrl", {24'd0, ctrl}, {24'd0, C_RST});
        check_eq("rst.ex_busy", {31'd0, ex_busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst.stall", {16'd0, stall_cycles}, 32'd0);
        check_eq("rst.timeout", {31'd0, mem_timeout}, 32'd0);
        cyc("idle", C_DEF, 1'b0);

        // T1 load-use.
        ID_EX_MemRead = 1'b1; ID_EX_RegRt = 5'd5; IF_ID_RegRs = 5'd5; IF_ID_RegRt = 5'd9;
        cyc("lu_rs", C_LU, 1'b0);
        ID_EX_RegRt = 5'd0; IF_ID_RegRs = 5'd0; IF_ID_RegRt = 5'd0;
        cyc("lu_r0", C_DEF, 1'b0);
        ID_EX_RegRt = 5'd7; IF_ID_RegRs = 5'd3; IF_ID_RegRt = 5'd7;
        cyc("lu_rt", C_LU, 1'b0);
        ID_EX_RegRt = 5'd5; IF_ID_RegRs = 5'd6; IF_ID_RegRt = 5'd7;
        cyc("lu_nomatch", C_DEF, 1'b0);
        ID_EX_MemRead = 1'b0; ID_EX_RegRt = 5'd5; IF_ID_RegRs = 5'd5;
        cyc("lu_noload", C_DEF, 1'b0);
        clear_inputs();

        // T4 branch vs load-use.
        branch_taken = 1'b1;
        cyc("br", C_BR, 1'b0);
        ID_EX_MemRead = 1'b1; ID_EX_RegRt = 5'd12; IF_ID_RegRs = 5'd12;
        cyc("br_lu", C_LU, 1'b0);
        clear_inputs();

        // T2 multi-cycle op, MUL_LAT=4.
        ID_EX_MultiCycle = 1'b1;
        cyc("mc1", C_HLD, 1'b0);
        cyc("mc2", C_HLD, 1'b1);
        cyc("mc3", C_HLD, 1'b1);
        cyc("mc4", C_DEF, 1'b1);
        ID_EX_MultiCycle = 1'b0;
        cyc("mc5", C_DEF, 1'b0);

        // T3 freeze mid-op plus a branch held across the freeze.
        ID_EX_MultiCycle = 1'b1;
        cyc("fz1", C_HLD, 1'b0);
        cyc("fz2", C_HLD, 1'b1);
        dmem_busy = 1'b1;
        cyc("fz3", C_FRZ, 1'b1);
        branch_taken = 1'b1;
        cyc("fz4", C_FRZ, 1'b1);
        dmem_busy = 1'b0;
        cyc("fz5", C_HLD, 1'b1);
        cyc("fz6", C_BR, 1'b1);
        clear_inputs();
        cyc("fz7", C_DEF, 1'b0);

        // Freeze in RUN beats a multi-cycle start; op then runs its full length.
        ID_EX_MultiCycle = 1'b1; dmem_busy = 1'b1;
        cyc("fzrun", C_FRZ, 1'b0);
        dmem_busy = 1'b0;
        cyc("fzrun_mc1", C_HLD, 1'b0);
        cyc("fzrun_mc2", C_HLD, 1'b1);
        cyc("fzrun_mc3", C_HLD, 1'b1);
        cyc("fzrun_mc4", C_DEF, 1'b1);
        clear_inputs();

        // T5 watchdog.
        dmem_busy = 1'b1;
        for (int i = 0; i < 63; i++) begin
            cyc("wd_busy", C_FRZ, 1'b0);
        end
        check_eq("wd63", {31'd0, mem_timeout}, 32'd0);
        cyc("wd_busy64", C_FRZ, 1'b0);
        check_eq("wd64", {31'd0, mem_timeout}, 32'd1);
        dmem_busy = 1'b0;
        cyc("wd_after1", C_DEF, 1'b0);
        cyc("wd_after2", C_DEF, 1'b0);
        check_eq("wd_sticky", {31'd0, mem_timeout}, 32'd1);

        // T6 reset while in EX_BUSY.
        ID_EX_MultiCycle = 1'b1;
        cyc("rmc1", C_HLD, 1'b0);
        cyc("rmc2", C_HLD, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("rmid.ctrl", {24'd0, ctrl}, {24'd0, C_RST});
        check_eq("rmid.ex_busy", {31'd0, ex_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ID_EX_MultiCycle = 1'b0;
        exp_stall = 0;
        #1;
        check_eq("rpost.stall", {16'd0, stall_cycles}, 32'd0);
        check_eq("rpost.timeout", {31'd0, mem_timeout}, 32'd0);
        cyc("rpost", C_DEF, 1'b0);
        ID_EX_MultiCycle = 1'b1;
        cyc("rpost_mc1", C_HLD, 1'b0);
        cyc("rpost_mc2", C_HLD, 1'b1);
        cyc("rpost_mc3", C_HLD, 1'b1);
        cyc("rpost_mc4", C_DEF, 1'b1);
        clear_inputs();
        cyc("rpost_end", C_DEF, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
